// File: rtl/csa_resolve.sv
// csa_resolve: pipelined carry-propagate adder that resolves a CSA sum/carry pair.
// Each pipeline stage adds one SEGW-bit segment, and the carry ripples from stage to stage.
// Operands travel alongside the pipe in delay registers, and so do the result segments already produced.
// Optional feature macro: CSA_RESOLVE_ZERO_EN adds the out_zero port.
// It is a sum==0 flag, AND-accumulated one segment per stage.
module csa_resolve #(
  parameter int DW   = 32,
  parameter int SEGW = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] s,
  input  logic [DW-1:0] c,
  input  logic          cin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] sum,
  output logic          cout
`ifdef CSA_RESOLVE_ZERO_EN
  ,
  output logic          out_zero
`endif
);

  localparam int NSEG = (DW + SEGW - 1) / SEGW;

  // Global advance: the whole pipe moves unless a held result is being refused.
  logic adv;

  // Stage inputs (from ports for stage 0, from previous stage registers otherwise)
  logic [DW-1:0] a_in  [NSEG];
  logic [DW-1:0] b_in  [NSEG];
  logic [DW-1:0] r_in  [NSEG];
  logic          ci_in [NSEG];
  logic          v_in  [NSEG];

  // Stage registers
  logic [DW-1:0] a_reg  [NSEG];
  logic [DW-1:0] b_reg  [NSEG];
  logic [DW-1:0] r_reg  [NSEG];
  logic          co_reg [NSEG];
  logic          v_reg  [NSEG];

`ifdef CSA_RESOLVE_ZERO_EN
  logic z_in  [NSEG];
  logic z_reg [NSEG];
`endif

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign out_valid = v_reg[NSEG-1];
  assign sum       = r_reg[NSEG-1];
  assign cout      = co_reg[NSEG-1];
`ifdef CSA_RESOLVE_ZERO_EN
  assign out_zero  = z_reg[NSEG-1];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NSEG; gi++) begin : g_stage
      localparam int LO = gi * SEGW;
      localparam int W  = ((DW - LO) < SEGW) ? (DW - LO) : SEGW;

      logic [W:0]    seg_add;
      logic [DW-1:0] r_next;

      if (gi == 0) begin : g_first
        // c carries weight 2; its top bit falls off (guard bit in the tree)
        assign a_in[gi]  = s;
        assign b_in[gi]  = {c[DW-2:0], 1'b0};
        assign r_in[gi]  = '0;
        assign ci_in[gi] = cin;
        assign v_in[gi]  = in_valid;
`ifdef CSA_RESOLVE_ZERO_EN
        assign z_in[gi]  = 1'b1;
`endif
      end else begin : g_chain
        assign a_in[gi]  = a_reg[gi-1];
        assign b_in[gi]  = b_reg[gi-1];
        assign r_in[gi]  = r_reg[gi-1];
        assign ci_in[gi] = co_reg[gi-1];
        assign v_in[gi]  = v_reg[gi-1];
`ifdef CSA_RESOLVE_ZERO_EN
        assign z_in[gi]  = z_reg[gi-1];
`endif
      end

      // Segment adder: splice this segment's result into the travelling result word
      always_comb begin
        seg_add = {1'b0, a_in[gi][LO +: W]} + {1'b0, b_in[gi][LO +: W]} + {{W{1'b0}}, ci_in[gi]};
        r_next  = r_in[gi];
        r_next[LO +: W] = seg_add[W-1:0];
      end

      // Stage register: shifts on adv, freezes otherwise; reset clears everything
      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          a_reg[gi]  <= '0;
          b_reg[gi]  <= '0;
          r_reg[gi]  <= '0;
          co_reg[gi] <= 1'b0;
          v_reg[gi]  <= 1'b0;
        end else if (adv) begin
          a_reg[gi]  <= a_in[gi];
          b_reg[gi]  <= b_in[gi];
          r_reg[gi]  <= r_next;
          co_reg[gi] <= seg_add[W];
          v_reg[gi]  <= v_in[gi];
        end
      end

`ifdef CSA_RESOLVE_ZERO_EN
      // Zero flag: this segment is zero and all lower segments were zero
      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          z_reg[gi] <= 1'b0;
        end else if (adv) begin
          z_reg[gi] <= z_in[gi] && (seg_add[W-1:0] == '0);
        end
      end
`endif
    end
  endgenerate

endmodule
